// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared core definitions used by the stage sequencer slice:
//   XLEN                  - architectural address width
//   STAGE_TIMEOUT_DEFAULT - default per-stage watchdog limit (cycles)
//   jump_ctrl_t           - redirect request bundle sampled at retire
//   seq_state_t           - sequencer FSM states
//   next_pc()             - PC update rule applied at retire
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

    localparam int XLEN                  = 32;
    localparam int STAGE_TIMEOUT_DEFAULT = 1024;

    typedef struct packed {
        logic            enable;
        logic [XLEN-1:0] target;
    } jump_ctrl_t;

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_HALTED = 1'b1
    } seq_state_t;

    // Redirect targets are forced word-aligned; otherwise fall through by 4.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur_pc,
                                                 input jump_ctrl_t      jump);
        if (jump.enable)
            return {jump.target[XLEN-1:2], 2'b00};
        return cur_pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_if
// Bundles the stage handshake, redirect/halt controls and status outputs.
//   master : environment side (drives stage_done/stage_skip/jump/halt_req)
//   slave  : sequencer side (drives stage_enable/stage_index/pc/retire/
//            instret/halted/timeout_error)
// -----------------------------------------------------------------------------
interface stage_sequencer_if
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 5
) ();

    localparam int IDX_W = $clog2(NUM_STAGES);

    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_skip;
    logic                  jump_enable;
    logic [XLEN-1:0]       jump_target;
    logic                  halt_req;

    logic [NUM_STAGES-1:0] stage_enable;
    logic [IDX_W-1:0]      stage_index;
    logic [XLEN-1:0]       pc;
    logic                  retire;
    logic [63:0]           instret;
    logic                  halted;
    logic                  timeout_error;

    modport master (
        output stage_done, stage_skip, jump_enable, jump_target, halt_req,
        input  stage_enable, stage_index, pc, retire, instret, halted, timeout_error
    );

    modport slave (
        input  stage_done, stage_skip, jump_enable, jump_target, halt_req,
        output stage_enable, stage_index, pc, retire, instret, halted, timeout_error
    );

endinterface

// File: rtl/stage_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// stage_watchdog
// Counts cycles spent in the currently active stage and flags expiry when the
// stage has been enabled for STAGE_TIMEOUT cycles without completing.
// Ports:
//   clock, reset  - clock / synchronous active-high reset
//   active        - sequencer is running (a stage is enabled)
//   stage_done    - the active stage completes this cycle (restarts the count)
//   expire        - combinational: this is the last allowed cycle and the
//                   stage did not complete
// -----------------------------------------------------------------------------
module stage_watchdog
    import stage_sequencer_pkg::*;
#(
    parameter int STAGE_TIMEOUT = STAGE_TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic stage_done,
    output logic expire
);

    localparam int CNT_W = $clog2(STAGE_TIMEOUT + 1);

    // Number of cycles already spent in the current stage; 0 on entry.
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || !active || stage_done)
            count_q <= '0;
        else
            count_q <= count_q + CNT_W'(1);
    end

    assign expire = active && !stage_done && (count_q == CNT_W'(STAGE_TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Steps an instruction through NUM_STAGES one-hot stages, skipping bypassed
// stages, retiring on completion of the final non-skipped stage, updating the
// PC (fall-through or redirect) and counting retired instructions. A halt
// request stops the sequencer after the next retire; only reset restarts it.
//
// Optional feature: define STAGE_SEQUENCER_TIMEOUT_EN to instantiate the
// stage_watchdog; a stage enabled for STAGE_TIMEOUT cycles without completing
// sets the sticky timeout_error and halts without retiring. Without the macro
// timeout_error is tied to 0.
//
// Ports:
//   clock, reset - clock / synchronous active-high reset
//   bus (slave)  - stage_done/stage_skip/jump_enable/jump_target/halt_req in;
//                  stage_enable/stage_index/pc/retire/instret/halted/
//                  timeout_error out
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int              NUM_STAGES    = 5,
    parameter logic [XLEN-1:0] RESET_VECTOR  = 32'h00010000,
    parameter int              STAGE_TIMEOUT = STAGE_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    stage_sequencer_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_STAGES);

    seq_state_t      state_q, state_d;
    logic [IDX_W-1:0] stage_q, stage_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [63:0]      instret_q, instret_d;
    logic             pending_q, pending_d;

    logic [IDX_W-1:0] next_idx;
    logic             has_next;
    logic             active_done;
    logic             retire_int;
    logic             expire;
    jump_ctrl_t       jump;

    assign jump        = '{enable: bus.jump_enable, target: bus.jump_target};
    assign active_done = bus.stage_done[stage_q];

    // Lowest non-skipped stage above the active one; the descending scan lets
    // the lowest match overwrite higher ones.
    always_comb begin
        has_next = 1'b0;
        next_idx = '0;
        for (int j = NUM_STAGES - 1; j >= 1; j--) begin
            if (j > int'(stage_q) && !bus.stage_skip[j]) begin
                has_next = 1'b1;
                next_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SEQ_RUN;
            stage_q   <= '0;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        pending_d  = pending_q;
        retire_int = 1'b0;
        if (state_q == SEQ_RUN) begin
            // A halt raised in the retire cycle itself still takes effect.
            pending_d = pending_q | bus.halt_req;
            if (active_done) begin
                if (has_next) begin
                    stage_d = next_idx;
                end else begin
                    retire_int = 1'b1;
                    instret_d  = instret_q + 64'd1;
                    pc_d       = next_pc(pc_q, jump);
                    stage_d    = '0;
                    if (pending_d)
                        state_d = SEQ_HALTED;
                end
            end else if (expire) begin
                state_d = SEQ_HALTED;
            end
        end
    end

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
    logic terr_q;

    stage_watchdog #(
        .STAGE_TIMEOUT (STAGE_TIMEOUT)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .active     (state_q == SEQ_RUN),
        .stage_done (active_done),
        .expire     (expire)
    );

    always_ff @(posedge clock) begin
        if (reset)
            terr_q <= 1'b0;
        else if (expire)
            terr_q <= 1'b1;
    end

    assign bus.timeout_error = terr_q;
`else
    assign expire            = 1'b0;
    assign bus.timeout_error = 1'b0;
`endif

    assign bus.stage_enable = (state_q == SEQ_RUN) ? (NUM_STAGES'(1) << stage_q) : '0;
    assign bus.stage_index  = stage_q;
    assign bus.pc           = pc_q;
    assign bus.retire       = retire_int && !reset;
    assign bus.instret      = instret_q;
    assign bus.halted       = (state_q == SEQ_HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Directed and randomized stimulus for stage_sequencer (NUM_STAGES=5,
// STAGE_TIMEOUT=8) against a behavioural model of the stage/retire rules.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int              NS = 5;
    localparam logic [XLEN-1:0] RV = 32'h00010000;
    localparam int              TO = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    stage_sequencer_if #(.NUM_STAGES(NS)) bus ();

    stage_sequencer #(
        .NUM_STAGES    (NS),
        .RESET_VECTOR  (RV),
        .STAGE_TIMEOUT (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int retire_seen = 0;

    // Behavioural model state
    int          m_stage;
    logic [31:0] m_pc;
    logic [63:0] m_instret;
    bit          m_halted, m_pending, m_terr;
    int          m_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stage   = 0;
        m_pc      = RV;
        m_instret = 64'd0;
        m_halted  = 1'b0;
        m_pending = 1'b0;
        m_terr    = 1'b0;
        m_wait    = 0;
    endtask

    function automatic int next_stage(input int k, input logic [NS-1:0] skip);
        for (int j = k + 1; j < NS; j++)
            if (!skip[j]) return j;
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [NS-1:0] d, input logic [NS-1:0] s,
                         input logic je, input logic [31:0] jt, input logic hr);
        reset           = r;
        bus.stage_done  = d;
        bus.stage_skip  = s;
        bus.jump_enable = je;
        bus.jump_target = jt;
        bus.halt_req    = hr;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model over the edge.
    task automatic cycle();
        bit              done;
        int              nxt;
        bit              exp_retire;
        logic [NS-1:0]   oh;
        @(negedge clock);
        done       = !m_halted && bus.stage_done[m_stage];
        nxt        = next_stage(m_stage, bus.stage_skip);
        exp_retire = !reset && done && (nxt < 0);
        oh         = '0;
        if (!m_halted) oh[m_stage] = 1'b1;
        check("stage_enable", 64'(bus.stage_enable), 64'(oh));
        if (!m_halted) check("stage_index", 64'(bus.stage_index), 64'(m_stage));
        check("pc", 64'(bus.pc), 64'(m_pc));
        check("instret", bus.instret, m_instret);
        check("halted", 64'(bus.halted), 64'(m_halted));
        check("timeout_error", 64'(bus.timeout_error), 64'(m_terr));
        check("retire", 64'(bus.retire), 64'(exp_retire));
        if (bus.retire === 1'b1) retire_seen++;
        if (reset) begin
            model_reset();
        end else if (!m_halted) begin
            m_pending = m_pending | bus.halt_req;
            if (done) begin
                m_wait = 0;
                if (nxt < 0) begin
                    m_instret = m_instret + 64'd1;
                    m_pc      = bus.jump_enable ? {bus.jump_target[31:2], 2'b00} : m_pc + 32'd4;
                    m_stage   = 0;
                    if (m_pending) m_halted = 1'b1;
                end else begin
                    m_stage = nxt;
                end
            end else begin
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
                if (m_wait == TO - 1) begin
                    m_terr   = 1'b1;
                    m_halted = 1'b1;
                    m_wait   = 0;
                end else begin
                    m_wait++;
                end
`else
                m_wait++;
`endif
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        drive(1'b1, '0, '0, 1'b0, 32'h0, 1'b0);
        @(posedge clock);
        #1;
        model_reset();
        cycles(2);
        check("rst_stage_enable", 64'(bus.stage_enable), 64'h1);
        check("rst_pc", 64'(bus.pc), 64'h10000);

        // Every stage completes immediately, nothing skipped
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b0);
        retire_seen = 0;
        cycles(5);
        check("full_retire_count", 64'(retire_seen), 64'd1);
        check("full_pc", 64'(bus.pc), 64'h10004);
        check("full_instret", bus.instret, 64'd1);
        cycles(10);
        check("full_pc_3", 64'(bus.pc), 64'h1000c);

        // Skip stages 1 and 2: 0,3,4
        drive(1'b0, '1, 5'b00110, 1'b0, 32'h0, 1'b0);
        retire_seen = 0;
        cycles(6);
        check("skip_retire_count", 64'(retire_seen), 64'd2);
        check("skip_instret", bus.instret, 64'd5);
        // Single-cycle instructions
        drive(1'b0, '1, 5'b11110, 1'b0, 32'h0, 1'b0);
        cycles(4);
        check("one_cycle_instret", bus.instret, 64'd9);
        check("one_cycle_pc", 64'(bus.pc), 64'h10024);

        // Redirect at retire, target forced word-aligned
        drive(1'b0, '1, 5'b11110, 1'b1, 32'h00010023, 1'b0);
        cycles(1);
        check("jump_pc", 64'(bus.pc), 64'h10020);
        // Redirect outside retire has no effect
        drive(1'b0, '0, '0, 1'b1, 32'h00020000, 1'b0);
        cycles(3);
        check("jump_offretire_pc", 64'(bus.pc), 64'h10020);

        // Randomized traffic with occasional reset and halt
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, NS'($urandom), NS'($urandom),
                  $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 39) == 0);
            cycle();
        end

        // Reset in the middle of an instruction (stage 3)
        drive(1'b1, '0, '0, 1'b0, 32'h0, 1'b0);
        cycles(1);
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b0);
        cycles(3);
        check("mid_stage3", 64'(bus.stage_index), 64'd3);
        drive(1'b1, '1, '0, 1'b1, 32'h00030000, 1'b0);
        retire_seen = 0;
        cycles(1);
        check("mid_no_retire", 64'(retire_seen), 64'd0);
        check("mid_stage0", 64'(bus.stage_index), 64'd0);
        check("mid_pc", 64'(bus.pc), 64'h10000);
        check("mid_instret", bus.instret, 64'd0);

        // Halt requested during stage 1
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b0);
        cycles(1);
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b1);
        cycles(1);
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b0);
        cycles(3);
        check("halt_halted", 64'(bus.halted), 64'd1);
        check("halt_enable", 64'(bus.stage_enable), 64'd0);
        cycles(6);
        check("halt_instret", bus.instret, 64'd1);
        check("halt_pc", 64'(bus.pc), 64'h10004);
        drive(1'b1, '0, '0, 1'b0, 32'h0, 1'b0);
        cycles(1);
        check("halt_cleared", 64'(bus.halted), 64'd0);

        // Stall in stage 2
        drive(1'b0, '1, '0, 1'b0, 32'h0, 1'b0);
        cycles(2);
        drive(1'b0, '0, '0, 1'b0, 32'h0, 1'b0);
        cycles(7);
        check("stall_7_halted", 64'(bus.halted), 64'd0);
        cycles(1);
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
        check("timeout_halted", 64'(bus.halted), 64'd1);
        check("timeout_flag", 64'(bus.timeout_error), 64'd1);
        check("timeout_pc", 64'(bus.pc), 64'h10000);
`else
        cycles(12);
        check("stall_halted", 64'(bus.halted), 64'd0);
        check("stall_flag", 64'(bus.timeout_error), 64'd0);
        check("stall_index", 64'(bus.stage_index), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
